seq_det_ctrl: RTL and testbench

Programmable controller and scheduler for serial bit-pattern detection. It loads a pattern configuration through a valid/ready handshake and arms or aborts a detection run. During a run it shifts qualified serial samples into a history register, flags matches in overlapping or non-overlapping mode, and counts them. The run ends when a match target is reached. It replaces hard-coded per-pattern Moore detectors with one configurable block, sequenced by a host or test controller.

---
 rtl/seq_det_ctrl_if.sv | 44 ++++
 rtl/seq_det_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Host-side bus of the programmable serial pattern detector: config handshake, run control, sample stream, status.
// With SEQ_DET_CTRL_TIMEOUT_EN defined the bus also carries the timeout pulse.
interface seq_det_ctrl_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
) ();
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               in_valid;
    logic               in;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic               timeout;
`endif

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, in_valid, in,
        input  cfg_ready, match, match_cnt, busy, done
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        , input timeout
`endif
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, in_valid, in,
        output cfg_ready, match, match_cnt, busy, done
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        , output timeout
`endif
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Configurable serial bit-pattern detector with run scheduling (IDLE/RUN/DONE) and saturating match counter.
// Optional idle-input timeout enabled by defining SEQ_DET_CTRL_TIMEOUT_EN.
module seq_det_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    seq_det_ctrl_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;

    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               match_q;
    logic               done_q;

    logic               cfg_fire;
    logic               run_start;
    logic               sample;
    logic               hit;
    logic               tgt_hit;
    logic [LEN_W-1:0]   len_clamp;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [CNT_W-1:0]   cnt_inc;

    assign cfg_fire  = bus.cfg_valid & (state != S_RUN);
    assign run_start = bus.start & (state != S_RUN);
    assign sample    = (state == S_RUN) & bus.in_valid & ~bus.abort;
    assign hist_nxt  = {hist_q[MAX_LEN-2:0], bus.in};
    assign fill_inc  = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign hit       = sample & (fill_inc == len_q) & (((hist_nxt ^ pat_q) & len_mask) == '0);
    assign tgt_hit   = (tgt_q != '0) & (cnt_inc == tgt_q);

    // Lengths outside 1..MAX_LEN are folded into range at latch time.
    always_comb begin
        len_clamp = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            len_clamp = LEN_W'(1);
        end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamp = LEN_W'(MAX_LEN);
        end
    end

    // Selects the low len_q history bits that take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] idle_q;
    logic            to_hit;
    logic            timeout_q;

    assign to_hit = (state == S_RUN) & ~bus.abort & ~bus.in_valid
                  & (idle_q + TO_W'(1) == TO_W'(TIMEOUT));

    // Consecutive no-sample cycles while running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit;
            if (run_start || bus.in_valid || to_hit) begin
                idle_q <= '0;
            end else if (state == S_RUN) begin
                idle_q <= idle_q + TO_W'(1);
            end
        end
    end

    assign bus.timeout = timeout_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (hit && tgt_hit) begin
                    state_nxt = S_DONE;
                end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt = S_IDLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = 1'b0;
        bus.cfg_ready = 1'b1;
        if (state == S_RUN) begin
            bus.busy      = 1'b1;
            bus.cfg_ready = 1'b0;
        end
    end

    // Configuration registers; a config offered with start is used by that run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
            len_q <= LEN_W'(1);
            ovl_q <= 1'b0;
            tgt_q <= '0;
        end else if (cfg_fire) begin
            pat_q <= bus.cfg_pattern;
            len_q <= len_clamp;
            ovl_q <= bus.cfg_overlap;
            tgt_q <= bus.cfg_target;
        end
    end

    // History, fill level and match accounting; non-overlap restarts the fill after a hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            match_q <= hit;
            done_q  <= hit & tgt_hit;
            if (run_start) begin
                hist_q <= '0;
                fill_q <= '0;
                cnt_q  <= '0;
            end else if (sample) begin
                hist_q <= hist_nxt;
                fill_q <= (hit && !ovl_q) ? '0 : fill_inc;
                if (hit) begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign bus.match     = match_q;
    assign bus.done      = done_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_seq_det_ctrl;
    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    localparam int          TIMEOUT = 16;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state: the run is a sequence of sampled bits and a
    // count of how many of them are still usable for the next match.
    bit               m_run;
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_tgt;
    int               m_cnt;
    int               m_seen;
    bit               q[$];
    bit               exp_match;
    bit               exp_done;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    int               m_idle;
    bit               exp_to;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit tail_ok();
        for (int k = 0; k < m_len; k++) begin
            if (q[q.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pat = '0; m_len = 1; m_ovl = 0; m_tgt = 0;
        m_cnt = 0; m_seen = 0; q.delete();
        exp_match = 0; exp_done = 0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        m_idle = 0; exp_to = 0;
`endif
    endtask

    task automatic model_edge(input bit cv, input logic [MAX_LEN-1:0] cp, input int cl, input bit co,
                              input int ct, input bit st, input bit ab, input bit iv, input bit ib);
        exp_match = 0;
        exp_done  = 0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        exp_to = 0;
`endif
        if (!m_run) begin
            if (cv) begin
                m_pat = cp;
                m_len = (cl == 0) ? 1 : ((cl > int'(MAX_LEN)) ? int'(MAX_LEN) : cl);
                m_ovl = co;
                m_tgt = ct;
            end
            if (st) begin
                m_run = 1; m_cnt = 0; m_seen = 0; q.delete();
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                m_idle = 0;
`endif
            end
        end else if (ab) begin
            m_run = 0;
        end else if (iv) begin
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
            m_idle = 0;
`endif
            q.push_back(ib);
            if (q.size() > MAX_LEN) void'(q.pop_front());
            m_seen++;
            if (m_seen >= m_len && tail_ok()) begin
                exp_match = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_ovl) m_seen = 0;
                if (m_tgt != 0 && m_cnt == m_tgt) begin
                    m_run = 0;
                    exp_done = 1;
                end
            end
        end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_run = 0; exp_to = 1; m_idle = 0;
            end
        end
`endif
    endtask

    // One clock: drive inputs, check the combinational ready, advance model and DUT, check registered outputs.
    task automatic step(input bit cv, input logic [MAX_LEN-1:0] cp, input int cl, input bit co,
                        input int ct, input bit st, input bit ab, input bit iv, input bit ib);
        bus.cfg_valid   = cv;
        bus.cfg_pattern = cp;
        bus.cfg_len     = LEN_W'(cl);
        bus.cfg_overlap = co;
        bus.cfg_target  = CNT_W'(ct);
        bus.start       = st;
        bus.abort       = ab;
        bus.in_valid    = iv;
        bus.in          = ib;
        #1;
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(!m_run));
        model_edge(cv, cp, cl, co, ct, st, ab, iv, ib);
        @(posedge clk);
        #1;
        chk("match", 32'(bus.match), 32'(exp_match));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
        chk("busy", 32'(bus.busy), 32'(m_run));
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        chk("timeout", 32'(bus.timeout), 32'(exp_to));
`endif
    endtask

    task automatic idle_cyc();
        step(0, '0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o, input int t);
        step(1, p, l, o, t, 0, 0, 0, 0);
    endtask

    task automatic go();
        step(0, '0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic stop();
        step(0, '0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(0, '0, 0, 0, 0, 0, 0, 1, bits[i]);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_match", 32'(bus.match), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.cfg_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
        bus.cfg_target = '0; bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in = 0;
        model_reset();
        #12;
        chk("init_match", 32'(bus.match), 32'd0);
        chk("init_cnt", 32'(bus.match_cnt), 32'd0);
        chk("init_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        #1;
        chk("init_ready", 32'(bus.cfg_ready), 32'd1);
        @(posedge clk);
        #1;

        // Non-overlapping 110110 over 110110110110.
        cfg(8'b0011_0110, 6, 0, 0); go(); feed(32'b110110110110, 12);
        chk("t1_cnt", 32'(bus.match_cnt), 32'd2);
        stop();
        // Same stream, overlapping.
        cfg(8'b0011_0110, 6, 1, 0); go(); feed(32'b110110110110, 12);
        chk("t2_cnt", 32'(bus.match_cnt), 32'd3);
        stop();
        // Target 2 on 101: done with the second match, trailing bits ignored, restart clears.
        cfg(8'b0000_0101, 3, 1, 2); go(); feed(32'b10101, 5);
        chk("t3_done", 32'(bus.done), 32'd1);
        feed(32'b111, 3);
        chk("t3_cnt", 32'(bus.match_cnt), 32'd2);
        chk("t3_busy", 32'(bus.busy), 32'd0);
        go();
        chk("t3_restart", 32'(bus.match_cnt), 32'd0);
        stop();
        // Gaps in in_valid do not shift.
        cfg(8'b0000_0011, 2, 1, 0); go();
        step(0, '0, 0, 0, 0, 0, 0, 1, 1); step(0, '0, 0, 0, 0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 0, 0, 1, 1); step(0, '0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_cnt", 32'(bus.match_cnt), 32'd1);
        stop();
        // len 0 stored as 1; config offered mid-run ignored.
        cfg(8'b1010_0101, 0, 1, 0); go(); feed(32'b1101, 4);
        chk("t5_cnt", 32'(bus.match_cnt), 32'd3);
        step(1, 8'b0000_0000, 1, 0, 1, 0, 0, 1, 1);
        chk("t5_cnt_run", 32'(bus.match_cnt), 32'd4);
        stop();
        // Abort after four bits, then a reset mid-run.
        cfg(8'b0011_0110, 6, 0, 0); go(); feed(32'b1101, 4); stop();
        chk("t6_busy", 32'(bus.busy), 32'd0);
        idle_cyc();
        cfg(8'b0000_0001, 1, 1, 0); go(); feed(32'b111, 3);
        reset_pulse();
        idle_cyc();

        for (int n = 0; n < 3000; n++) begin
            bit cv, co, st, ab, iv, ib;
            int cl, ct;
            logic [MAX_LEN-1:0] cp;
            cv = ($urandom_range(0, 99) < 8);
            cp = MAX_LEN'($urandom);
            cl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
            co = 1'($urandom_range(0, 1));
            ct = int'($urandom_range(0, 4));
            st = ($urandom_range(0, 99) < 10);
            ab = ($urandom_range(0, 99) < 3);
            iv = ($urandom_range(0, 99) < 75);
            ib = 1'($urandom_range(0, 1));
            step(cv, cp, cl, co, ct, st, ab, iv, ib);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
